xalu_seq: RTL and testbench

- Multi-cycle sequencer that drives the team's combinational 4-bit ALU slice one nibble per clock.
- Executes NIBBLES*4-bit operations by chaining slice carries through a register.
- Sits between a command/result handshake interface and one slice instance. The slice is external to this block.
- Uses the same 4-bit function-code encoding as the slice.

---
 rtl/xalu_pkg.sv | 27 ++
 rtl/xalu_nib_sel.sv | 43 ++++
 rtl/xalu_seq.sv | 196 +++++++++++++++++++
 tb/tb_xalu_seq.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xalu_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: slice function codes,
// FSM state type and an illegal-op helper.
package xalu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_AND   = 4'd1;
  localparam logic [3:0] OP_OR    = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_PASSA = 4'd4;
  localparam logic [3:0] OP_PASSB = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_SHL   = 4'd7;
  localparam logic [3:0] OP_COM   = 4'd8;
  localparam logic [3:0] OP_LAST  = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Function codes above OP_LAST have no slice behaviour.
  function automatic logic op_illegal(input logic [3:0] op);
    return (op > OP_LAST);
  endfunction

endpackage

// File: rtl/xalu_nib_sel.sv
// Nibble selector: fetches nibble k of both operands and builds the result
// vector with nibble k replaced. k = i_idx, or NIBBLES-1-i_idx when
// i_msb_first is set (SHR walks the word from the top).
module xalu_nib_sel #(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned W  = 4 * NIBBLES,
  localparam int unsigned IW = $clog2(NIBBLES)
) (
  input  logic [IW-1:0] i_idx,
  input  logic          i_msb_first,
  input  logic [W-1:0]  i_a,
  input  logic [W-1:0]  i_b,
  input  logic [W-1:0]  i_res,
  input  logic [3:0]    i_nib,
  output logic [3:0]    o_a,
  output logic [3:0]    o_b,
  output logic [W-1:0]  o_res
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  logic [IW-1:0] w_k;

  // Map the sequence index onto the physical nibble position.
  always_comb begin
    w_k = i_msb_first ? (LAST_IDX - i_idx) : i_idx;
  end

  // Operand fetch and result insert at nibble w_k.
  always_comb begin
    o_a   = '0;
    o_b   = '0;
    o_res = i_res;
    for (int unsigned n = 0; n < NIBBLES; n++) begin
      if (w_k == IW'(n)) begin
        o_a              = i_a[4*n +: 4];
        o_b              = i_b[4*n +: 4];
        o_res[4*n +: 4]  = i_nib;
      end
    end
  end

endmodule

// File: rtl/xalu_seq.sv
// Multi-cycle sequencer driving an external combinational 4-bit ALU slice one
// nibble per clock, chaining carries through a register.
// Optional signed ADD overflow flag: define XALU_SEQ_OVF_EN.
module xalu_seq
  import xalu_pkg::*;
#(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_ci,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_d,
  output logic         res_co,
  output logic         res_zero,
  output logic         res_negz,
  output logic         res_equ,
  output logic         res_illegal,
  output logic         res_ovf,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic [3:0]   alu_f,
  output logic         alu_ci_right,
  output logic         alu_ci_left,
  input  logic [3:0]   alu_d,
  input  logic         alu_co_left,
  input  logic         alu_co_right,
  input  logic         alu_zero,
  input  logic         alu_negz,
  input  logic         alu_equ
);

  localparam int unsigned   IW       = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_op;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_ci;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic [W-1:0]  r_res;
  logic          r_co;
  logic          r_zero;
  logic          r_negz;
  logic          r_equ;
  logic          r_illegal;

  logic          w_cmd_fire;
  logic          w_res_fire;
  logic          w_run;
  logic          w_first;
  logic          w_last;
  logic          w_shr;
  logic          w_chain_right;
  logic [3:0]    w_a_nib;
  logic [3:0]    w_b_nib;
  logic [W-1:0]  w_res_ins;

  assign w_cmd_fire    = cmd_valid & cmd_ready;
  assign w_res_fire    = res_valid & res_ready;
  assign w_run         = (r_state == RUN);
  assign w_first       = (r_idx == '0);
  assign w_last        = (r_idx == LAST_IDX);
  assign w_shr         = (r_op == OP_SHR);
  assign w_chain_right = (r_op == OP_ADD) || (r_op == OP_SHL);

  xalu_nib_sel #(.NIBBLES(NIBBLES)) u_nib_sel (
    .i_idx       (r_idx),
    .i_msb_first (w_shr),
    .i_a         (r_a),
    .i_b         (r_b),
    .i_res       (r_res),
    .i_nib       (alu_d),
    .o_a         (w_a_nib),
    .o_b         (w_b_nib),
    .o_res       (w_res_ins)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = RUN;
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Slice drive: operands, function code and chained carry, only while running.
  always_comb begin
    alu_a        = '0;
    alu_b        = '0;
    alu_f        = '0;
    alu_ci_right = 1'b0;
    alu_ci_left  = 1'b0;
    if (w_run) begin
      alu_a = w_a_nib;
      alu_b = w_b_nib;
      alu_f = r_op;
      if (w_chain_right) alu_ci_right = w_first ? r_ci : r_carry;
      if (w_shr)         alu_ci_left  = w_first ? r_ci : r_carry;
    end
  end

  // Command latch and per-nibble capture of slice results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_ci      <= 1'b0;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      r_res     <= '0;
      r_co      <= 1'b0;
      r_zero    <= 1'b0;
      r_negz    <= 1'b0;
      r_equ     <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_cmd_fire) begin
      r_op  <= cmd_op;
      r_a   <= cmd_a;
      r_b   <= cmd_b;
      r_ci  <= cmd_ci;
      r_idx <= '0;
    end else if (w_run) begin
      r_idx     <= r_idx + IW'(1);
      r_res     <= w_res_ins;
      r_carry   <= w_shr ? alu_co_right : alu_co_left;
      // flags restart on the first nibble instead of being preset at accept
      r_zero    <= alu_zero & (w_first | r_zero);
      r_negz    <= alu_negz & (w_first | r_negz);
      r_equ     <= alu_equ  & (w_first | r_equ);
      r_illegal <= op_illegal(r_op);
      if (w_last) begin
        if (w_chain_right) r_co <= alu_co_left;
        else if (w_shr)    r_co <= alu_co_right;
        else               r_co <= 1'b0;
      end
    end
  end

  assign res_d       = r_res;
  assign res_co      = r_co;
  assign res_zero    = r_zero;
  assign res_negz    = r_negz;
  assign res_equ     = r_equ;
  assign res_illegal = r_illegal;

`ifdef XALU_SEQ_OVF_EN
  logic r_ovf;

  // Signed ADD overflow from the top nibble's sign bits at the final capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == IDLE) begin
      r_ovf <= 1'b0;
    end else if (w_run && w_last) begin
      r_ovf <= (r_op == OP_ADD) && (alu_a[3] == alu_b[3]) && (alu_d[3] != alu_a[3]);
    end
  end

  assign res_ovf = r_ovf;
`else
  assign res_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_xalu_seq.sv
// Self-checking bench for xalu_seq (NIBBLES=4) with a behavioural slice model
// and a whole-word reference model.
module tb_xalu_seq;
  import xalu_pkg::*;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [3:0]   cmd_op = '0;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic         cmd_ci = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_d;
  logic         res_co, res_zero, res_negz, res_equ, res_illegal, res_ovf;
  logic [3:0]   alu_a, alu_b, alu_f, alu_d;
  logic         alu_ci_right, alu_ci_left;
  logic         alu_co_left, alu_co_right, alu_zero, alu_negz, alu_equ;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xalu_seq #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ci(cmd_ci),
    .res_valid(res_valid), .res_ready(res_ready), .res_d(res_d),
    .res_co(res_co), .res_zero(res_zero), .res_negz(res_negz),
    .res_equ(res_equ), .res_illegal(res_illegal), .res_ovf(res_ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_ci_right(alu_ci_right), .alu_ci_left(alu_ci_left),
    .alu_d(alu_d), .alu_co_left(alu_co_left), .alu_co_right(alu_co_right),
    .alu_zero(alu_zero), .alu_negz(alu_negz), .alu_equ(alu_equ)
  );

  // Behavioural 4-bit slice; illegal codes return all zeros.
  always_comb begin
    alu_d = '0; alu_co_left = 1'b0; alu_co_right = 1'b0;
    alu_zero = 1'b0; alu_negz = 1'b0; alu_equ = 1'b0;
    case (alu_f)
      OP_ADD:   {alu_co_left, alu_d} = {1'b0, alu_a} + {1'b0, alu_b} + 5'(alu_ci_right);
      OP_AND:   alu_d = alu_a & alu_b;
      OP_OR:    alu_d = alu_a | alu_b;
      OP_XOR:   alu_d = alu_a ^ alu_b;
      OP_PASSA: alu_d = alu_a;
      OP_PASSB: alu_d = alu_b;
      OP_SHR:   begin alu_d = {alu_ci_left, alu_a[3:1]}; alu_co_right = alu_a[0]; end
      OP_SHL:   begin alu_d = {alu_a[2:0], alu_ci_right}; alu_co_left = alu_a[3]; end
      OP_COM:   alu_d = ~alu_a;
      default:  alu_d = '0;
    endcase
    if (alu_f <= OP_LAST) begin
      alu_zero = (alu_d == 4'h0);
      alu_negz = (alu_d == 4'hF);
      alu_equ  = (alu_a == alu_b);
    end
  end

  typedef struct packed {
    logic [W-1:0] d;
    logic co, z, nz, eq, il, ov;
  } exp_t;

  // Whole-word reference of what the sequenced slice should produce.
  function automatic exp_t ref_model(input logic [3:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic ci);
    exp_t e;
    logic [W:0] s;
    e = '0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b} + (W+1)'(ci); e.d = s[W-1:0]; e.co = s[W]; end
      4'd1: e.d = a & b;
      4'd2: e.d = a | b;
      4'd3: e.d = a ^ b;
      4'd4: e.d = a;
      4'd5: e.d = b;
      4'd6: begin e.d = {ci, a[W-1:1]}; e.co = a[0]; end
      4'd7: begin e.d = {a[W-2:0], ci}; e.co = a[W-1]; end
      4'd8: e.d = ~a;
      default: e.il = 1'b1;
    endcase
    if (!e.il) begin
      e.z  = (e.d == '0);
      e.nz = (e.d == '1);
      e.eq = (a == b);
    end
`ifdef XALU_SEQ_OVF_EN
    e.ov = (op == 4'd0) && (a[W-1] == b[W-1]) && (e.d[W-1] != a[W-1]);
`endif
    return e;
  endfunction

  // Offer one command, record alu_a per RUN cycle, return cycles to res_valid.
  task automatic do_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, output int lat, output logic [15:0] seq);
    int guard;
    guard = 0;
    seq = '0;
    @(negedge clk);
    while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_ci = ci;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (res_valid) break;
      if (lat < 4) seq[4*lat +: 4] = alu_a;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic take_result();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || res_d !== '0) begin
      failures++;
      $display("FAIL reset_hs: cmd_ready=%b res_valid=%b res_d=%h want 1 0 0000", cmd_ready, res_valid, res_d);
    end
    checks++;
    if ({res_co, res_zero, res_negz, res_equ, res_illegal, res_ovf} !== 6'b0 ||
        {alu_a, alu_b, alu_f, alu_ci_right, alu_ci_left} !== 14'b0) begin
      failures++;
      $display("FAIL reset_outs: flags=%b alu=%h%h%h ci=%b%b want all 0",
               {res_co, res_zero, res_negz, res_equ, res_illegal, res_ovf}, alu_a, alu_b, alu_f, alu_ci_right, alu_ci_left);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat; logic [15:0] seq; exp_t e;
    do_cmd(OP_ADD, 16'h0FFF, 16'h0001, 1'b0, lat, seq);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL add_latency: got %0d want 4", lat); end
    checks++;
    if (res_d !== 16'h1000 || res_co !== 1'b0 || res_zero !== 1'b0) begin
      failures++; $display("FAIL add_carry_chain: d=%h co=%b z=%b want 1000 0 0", res_d, res_co, res_zero);
    end
    take_result();
    do_cmd(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, lat, seq);
    checks++;
    if (res_d !== 16'h0000 || res_co !== 1'b1 || res_zero !== 1'b1 || res_ovf !== 1'b0) begin
      failures++; $display("FAIL add_wrap: d=%h co=%b z=%b ovf=%b want 0000 1 1 0", res_d, res_co, res_zero, res_ovf);
    end
    take_result();
    do_cmd(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, lat, seq);
    e = ref_model(OP_ADD, 16'h7FFF, 16'h0001, 1'b0);
    checks++;
    if (res_d !== 16'h8000 || res_ovf !== e.ov) begin
      failures++; $display("FAIL add_ovf: d=%h ovf=%b want 8000 %b", res_d, res_ovf, e.ov);
    end
    take_result();
  endtask

  task automatic test_shift();
    int lat; logic [15:0] seq;
    do_cmd(OP_SHR, 16'h8001, 16'h0000, 1'b1, lat, seq);
    checks++;
    if (seq !== 16'h1008) begin failures++; $display("FAIL shr_order: alu_a seq (first..last) %h %h %h %h want 8 0 0 1", seq[3:0], seq[7:4], seq[11:8], seq[15:12]); end
    checks++;
    if (res_d !== 16'hC000 || res_co !== 1'b1) begin failures++; $display("FAIL shr_result: d=%h co=%b want c000 1", res_d, res_co); end
    take_result();
    do_cmd(OP_SHL, 16'h8001, 16'h0000, 1'b0, lat, seq);
    checks++;
    if (seq !== 16'h8001) begin failures++; $display("FAIL shl_order: alu_a seq (first..last) %h %h %h %h want 1 0 0 8", seq[3:0], seq[7:4], seq[11:8], seq[15:12]); end
    checks++;
    if (res_d !== 16'h0002 || res_co !== 1'b1) begin failures++; $display("FAIL shl_result: d=%h co=%b want 0002 1", res_d, res_co); end
    take_result();
  endtask

  task automatic test_logic();
    int lat; logic [15:0] seq;
    do_cmd(OP_COM, 16'h0000, 16'h5A5A, 1'b0, lat, seq);
    checks++;
    if (res_d !== 16'hFFFF || res_negz !== 1'b1 || res_zero !== 1'b0) begin
      failures++; $display("FAIL com_negz: d=%h negz=%b z=%b want ffff 1 0", res_d, res_negz, res_zero);
    end
    take_result();
    do_cmd(OP_XOR, 16'h1234, 16'h1234, 1'b0, lat, seq);
    checks++;
    if (res_d !== 16'h0000 || res_zero !== 1'b1 || res_equ !== 1'b1) begin
      failures++; $display("FAIL xor_equ: d=%h z=%b equ=%b want 0000 1 1", res_d, res_zero, res_equ);
    end
    take_result();
    do_cmd(4'hA, 16'hFFFF, 16'h1111, 1'b1, lat, seq);
    checks++;
    if (res_d !== 16'h0000 || res_illegal !== 1'b1 || res_co !== 1'b0 || lat !== 4) begin
      failures++; $display("FAIL illegal_op: d=%h il=%b co=%b lat=%0d want 0000 1 0 4", res_d, res_illegal, res_co, lat);
    end
    take_result();
  endtask

  task automatic test_hold();
    int lat; logic [15:0] seq; logic [W+5:0] snap; int bad;
    do_cmd(OP_ADD, 16'h1357, 16'h2468, 1'b1, lat, seq);
    snap = {res_d, res_co, res_zero, res_negz, res_equ, res_illegal, res_ovf};
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cmd_valid = (i == 3);
      @(negedge clk);
      if ({res_d, res_co, res_zero, res_negz, res_equ, res_illegal, res_ovf} !== snap ||
          res_valid !== 1'b1 || cmd_ready !== 1'b0) bad++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (bad != 0 || res_d !== 16'h37C0) begin
      failures++; $display("FAIL hold_stable: unstable cycles=%0d d=%h want 0 37c0", bad, res_d);
    end
    // handshake with a command offered in the same cycle: must not be taken from DONE
    res_ready = 1'b1; cmd_valid = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
      failures++; $display("FAIL done_to_idle: cmd_ready=%b res_valid=%b want 1 0", cmd_ready, res_valid);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL no_stray_accept: cmd_ready=%b want 1", cmd_ready); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] seq;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 16'hABCD; cmd_b = 16'h1111; cmd_ci = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || res_d !== '0 ||
        {res_co, res_zero, res_negz, res_equ, res_illegal, res_ovf} !== 6'b0 ||
        {alu_a, alu_b, alu_f, alu_ci_right, alu_ci_left} !== 14'b0) begin
      failures++; $display("FAIL reset_abort: cmd_ready=%b res_valid=%b d=%h alu_a=%h want 1 0 0000 0", cmd_ready, res_valid, res_d, alu_a);
    end
    @(negedge clk);
    rst = 1'b0;
    do_cmd(OP_ADD, 16'h1234, 16'h4321, 1'b1, lat, seq);
    checks++;
    if (res_d !== 16'h5556 || res_co !== 1'b0 || lat !== 4) begin
      failures++; $display("FAIL after_reset_add: d=%h co=%b lat=%0d want 5556 0 4", res_d, res_co, lat);
    end
    take_result();
  endtask

  task automatic test_random();
    int lat; logic [15:0] seq; exp_t e;
    logic [3:0] op; logic [W-1:0] a, b; logic ci;
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = W'($urandom);
      b  = (n % 7 == 0) ? a : W'($urandom);
      ci = 1'($urandom);
      e  = ref_model(op, a, b, ci);
      do_cmd(op, a, b, ci, lat, seq);
      checks++;
      if (lat !== 4 || res_d !== e.d || res_co !== e.co || res_zero !== e.z || res_negz !== e.nz ||
          res_equ !== e.eq || res_illegal !== e.il || res_ovf !== e.ov) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h ci=%b: lat=%0d d=%h co/z/nz/eq/il/ov=%b%b%b%b%b%b want 4 %h %b%b%b%b%b%b",
                 n, op, a, b, ci, lat, res_d, res_co, res_zero, res_negz, res_equ, res_illegal, res_ovf,
                 e.d, e.co, e.z, e.nz, e.eq, e.il, e.ov);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      take_result();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_shift();
    test_logic();
    test_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
